// File: rtl/bsa_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package bsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int unsigned BSA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// Gate-level 1-bit full adder: two half-adder stages plus an OR of their carries.
module serial_fa_cell (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   logic w_ha0_s;
   logic w_ha0_c;
   logic w_ha1_c;

   xor u_ha0_x (w_ha0_s, a, b);
   and u_ha0_a (w_ha0_c, a, b);

   xor u_ha1_x (sum, w_ha0_s, cin);
   and u_ha1_a (w_ha1_c, w_ha0_s, cin);

   or  u_co    (cout, w_ha0_c, w_ha1_c);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder/subtractor: one bit pair per clock, LSB first, through a
// single full-adder cell with the carry held in a flop between bits.
module bit_serial_adder
   import bsa_pkg::*;
#(
   parameter int unsigned WIDTH = BSA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CW-1:0]    r_cnt;

   logic             w_fa_sum;
   logic             w_fa_co;

   serial_fa_cell u_fa (
      .sum  (w_fa_sum),
      .cout (w_fa_co),
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry)
   );

   // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= op_sub ? ~b : b;
                  r_carry <= op_sub ? ~cin : cin;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
               r_a     <= {1'b0, r_a[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_carry <= w_fa_co;
               if (r_cnt == CNT_LAST) begin
                  r_cout  <= w_fa_co;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign sum       = r_sum;
   assign cout      = r_cout;

endmodule
